// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - stall/branch/halt controls and PC/fetch status bundle for pc_sequencer
interface pc_sequencer_if #(
  parameter int nbits = 7
);
  logic             stall;
  logic             branch_req;
  logic [nbits-1:0] branch_target;
  logic             halt;
  logic [nbits-1:0] pc;
  logic [nbits-1:0] next_pc;
  logic             dec;
  logic             flush;
  logic             fetch_valid;
  logic             halted;
  logic             trap;

  modport master (
    output stall, branch_req, branch_target, halt,
    input  pc, next_pc, dec, flush, fetch_valid, halted, trap
  );

  modport slave (
    input  stall, branch_req, branch_target, halt,
    output pc, next_pc, dec, flush, fetch_valid, halted, trap
  );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer (RUN/FLUSH/HALT); optional PC_WRAP_TRAP_EN turns PC wrap into a trap
module pc_sequencer #(
  parameter int nbits        = 7,
  parameter int FLUSH_CYCLES = 2,
  parameter int RESET_VECTOR = 0
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.slave bus
);
  typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

  localparam logic [nbits-1:0] reset_pc   = nbits'(RESET_VECTOR);
  localparam logic [3:0]       flush_load = 4'(FLUSH_CYCLES);
  localparam logic [nbits-1:0] pc_one     = nbits'(1);

  state_t           state_q, state_d;
  logic [nbits-1:0] pc_q, pc_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             flush_q, flush_d;
  logic             fv_q, fv_d;
  logic             halted_q, halted_d;
  logic             dec_sel;
`ifdef PC_WRAP_TRAP_EN
  logic             trap_q, trap_d;
`endif

  // Next-state and PC-mux selection; priority is halt > branch > stall > increment.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    flush_d  = 1'b0;
    fv_d     = 1'b0;
    halted_d = halted_q;
    dec_sel  = 1'b0;
`ifdef PC_WRAP_TRAP_EN
    trap_d   = trap_q;
`endif
    case (state_q)
      RUN: begin
        if (bus.halt) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end else if (bus.branch_req) begin
          dec_sel = 1'b1;
          pc_d    = bus.branch_target;
          cnt_d   = flush_load;
          flush_d = 1'b1;
          state_d = FLUSH;
        end else if (!bus.stall) begin
`ifdef PC_WRAP_TRAP_EN
          // An increment off the top of the address space traps instead of wrapping.
          if (&pc_q) begin
            trap_d   = 1'b1;
            halted_d = 1'b1;
            state_d  = HALT;
          end else begin
            pc_d = pc_q + pc_one;
            fv_d = 1'b1;
          end
`else
          pc_d = pc_q + pc_one;
          fv_d = 1'b1;
`endif
        end
      end
      FLUSH: begin
        if (bus.halt) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end else if (!bus.stall) begin
          // The last suppressed cycle hands straight back to RUN with the target valid.
          if (cnt_q <= 4'd1) begin
            cnt_d   = 4'd0;
            state_d = RUN;
            fv_d    = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

  // State registers; reset wins over every other input in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      pc_q     <= reset_pc;
      cnt_q    <= 4'd0;
      flush_q  <= 1'b0;
      fv_q     <= 1'b0;
      halted_q <= 1'b0;
`ifdef PC_WRAP_TRAP_EN
      trap_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      flush_q  <= flush_d;
      fv_q     <= fv_d;
      halted_q <= halted_d;
`ifdef PC_WRAP_TRAP_EN
      trap_q   <= trap_d;
`endif
    end
  end

  assign bus.pc          = pc_q;
  assign bus.next_pc     = rst ? reset_pc : pc_d;
  assign bus.dec         = dec_sel & ~rst;
  assign bus.flush       = flush_q;
  assign bus.fetch_valid = fv_q;
  assign bus.halted      = halted_q;
`ifdef PC_WRAP_TRAP_EN
  assign bus.trap        = trap_q;
`else
  assign bus.trap        = 1'b0;
`endif
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter nbits, default 7, giving the program counter width in bits.
REQ-002 The block SHALL have parameter FLUSH_CYCLES, default 2, giving the number of fetch-suppressed cycles after a taken branch (legal range 1..15).
REQ-003 The block SHALL have parameter RESET_VECTOR, default 0, giving the PC value loaded on reset.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 stall  input  1  pipeline stall request; hold PC.
REQ-007 branch_req  input  1  taken branch/jump resolved this cycle.
REQ-008 branch_target  input  nbits  destination PC for branch_req.
REQ-009 halt  input  1  halt request; freezes sequencing until reset.
REQ-010 pc  output  nbits  registered current fetch address.
REQ-011 next_pc  output  nbits  combinational value pc takes at the next edge.
REQ-012 dec  output  1  combinational PC-mux select: 1 = branch target, 0 = sequential path.
REQ-013 flush  output  1  registered; kills wrong-path instructions in the pipeline.
REQ-014 fetch_valid  output  1  registered; instruction at pc is to be issued.
REQ-015 halted  output  1  registered; block is in HALT.
REQ-016 trap  output  1  registered; PC overflow trap (PC_WRAP_TRAP_EN only, otherwise tied 0).

Function
REQ-017 The FSM SHALL have three states: RUN, FLUSH and HALT.
REQ-018 Event priority each cycle SHALL be halt > branch_req > stall > increment.
REQ-019 In RUN with halt=1, next_pc SHALL equal pc and the state SHALL move to HALT.
REQ-020 In RUN with branch_req=1 and halt=0, dec SHALL be 1, next_pc SHALL equal branch_target, flush SHALL be 1 on the following cycle, the flush counter SHALL load FLUSH_CYCLES, and the state SHALL move to FLUSH (stall is ignored).
REQ-021 In RUN with stall=1 and no halt or branch, next_pc SHALL equal pc and fetch_valid SHALL be 0 the next cycle.
REQ-022 Otherwise in RUN, next_pc SHALL equal pc+1, modulo 2^nbits, and fetch_valid SHALL be 1.
REQ-023 dec SHALL be 0 in every cycle except the branch-accept cycle of REQ-020.
REQ-024 flush SHALL be a one-cycle pulse per accepted branch.
REQ-025 In FLUSH, fetch_valid SHALL be 0 and pc SHALL hold; the counter SHALL decrement each cycle with stall=0 and freeze while stall=1; the state SHALL return to RUN when the counter reaches 0 (fetch_valid=1 on the first RUN cycle, pc=target).
REQ-026 In FLUSH, branch_req SHALL be ignored and halt SHALL move the state to HALT immediately.
REQ-027 In HALT, pc SHALL hold, fetch_valid=0, halted=1, and all inputs except rst SHALL be ignored.
REQ-028 With FLUSH_CYCLES=2, a branch accepted at edge N SHALL give pc=target at N, fetch_valid=0 at N and N+1, and fetch_valid=1 from N+2.

Reset
REQ-029 With rst=1 at an edge, the block SHALL set pc=RESET_VECTOR, state=RUN, counter=0, flush=0, fetch_valid=0, halted=0 and trap=0, overriding all other inputs in any state, including mid-FLUSH.
REQ-030 On the first edge after rst deasserts, the block SHALL behave per RUN, with fetch_valid becoming 1 if no stall.

Configuration
REQ-031 Macro PC_WRAP_TRAP_EN defined: a sequential increment from pc=2^nbits-1 SHALL NOT wrap; pc SHALL hold, trap=1 and halted=1, and state=HALT. Branches to any target SHALL remain legal.
REQ-032 Macro PC_WRAP_TRAP_EN undefined: the increment SHALL wrap to 0, and trap SHALL be constant 0.

Verification
REQ-033 Reset then 5 idle cycles -> pc 0,1,2,3,4, fetch_valid=1 from the first post-reset edge, and dec=0 throughout.
REQ-034 At pc=0x10, assert branch_req with target 0x40 -> dec=1 that cycle; then pc=0x40, a one-cycle flush, fetch_valid=0 for 2 cycles, then pc 0x41.
REQ-035 At pc=0x05, assert stall and branch_req together -> branch wins and pc=target; stall alone for 3 cycles -> pc holds 0x05 and fetch_valid=0.
REQ-036 Assert halt during FLUSH -> HALT with halted=1; then branch/stall ignored; then rst -> pc=0 and RUN.
REQ-037 At pc=0x7F with nbits=7 and no stall -> pc=0x00 without the macro; with PC_WRAP_TRAP_EN, pc=0x7F, trap=1 and halted=1.
REQ-038 Assert rst during FLUSH (counter=1) -> the next cycle has pc=RESET_VECTOR, flush=0, state RUN, and no residual suppressed cycle.
